// File: rtl/fmov_rs.sv
// Reservation station for the sign-only FP moves (fmov/fneg/fabs/fnabs).
// Age-ordered compacted entries, CDB wake-up, oldest-ready dispatch with issue bypass.

package fmov_rs_pkg;
   localparam int ROB_WIDTH = 4;

   typedef struct packed {
      logic                 valid;
      logic [ROB_WIDTH-1:0] tag;
      logic [31:0]          data;
   } cdb_t;
endpackage

module fmov_rs
   import fmov_rs_pkg::*;
#(
   parameter  int N_ENTRY = 4,
   localparam int CNT_W   = $clog2(N_ENTRY + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           inst_op,
   input  cdb_t [1:0]           fpr_read,
   input  cdb_t                 fpr_cdb,
   input  logic [ROB_WIDTH-1:0] fpr_issue_tag,
   input  logic                 issue_req_valid,
   output logic                 issue_req_ready,
   output logic                 fpr_cdb_req_valid,
   input  logic                 fpr_cdb_req_ready,
   output logic [ROB_WIDTH-1:0] tag,
   output logic [31:0]          result,
   output logic [CNT_W-1:0]     count
);

   function automatic logic [31:0] sign_mod(input logic [1:0] op, input logic [31:0] d);
      case (op)
         2'b00:   return d;
         2'b01:   return {~d[31], d[30:0]};
         2'b10:   return {1'b0, d[30:0]};
         default: return {1'b1, d[30:0]};
      endcase
   endfunction

   // Entry storage, index 0 is the oldest
   logic [N_ENTRY-1:0]   valid_reg, valid_next;
   logic [N_ENTRY-1:0]   opd_valid_reg, opd_valid_next;
   logic [ROB_WIDTH-1:0] tag_reg      [N_ENTRY];
   logic [ROB_WIDTH-1:0] tag_next     [N_ENTRY];
   logic [1:0]           op_reg       [N_ENTRY];
   logic [1:0]           op_next      [N_ENTRY];
   logic [ROB_WIDTH-1:0] opd_tag_reg  [N_ENTRY];
   logic [ROB_WIDTH-1:0] opd_tag_next [N_ENTRY];
   logic [31:0]          opd_data_reg [N_ENTRY];
   logic [31:0]          opd_data_next[N_ENTRY];
   logic [CNT_W-1:0]     count_reg, count_next;
   logic [31:0]          result_reg;

   // Entries after this cycle's wake-up
   logic [N_ENTRY-1:0]   upd_opd_valid;
   logic [31:0]          upd_data[N_ENTRY];

   // Dispatch candidates; index N_ENTRY is the instruction being issued
   logic [N_ENTRY:0]     cand_valid;
   logic [ROB_WIDTH-1:0] cand_tag [N_ENTRY+1];
   logic [31:0]          cand_data[N_ENTRY+1];

   logic                 stored_req, full, accept, dispatch;
   logic                 new_opd_valid;
   logic [31:0]          new_data;
   logic [CNT_W-1:0]     sel_idx, ins_pos;
   logic [31:0]          sel_data;
   logic                 rm_stored, store_new;
   logic                 unused_read;

   assign unused_read = ^fpr_read[1];

   generate
      for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_wake
         logic wake;
         assign wake = valid_reg[gi] && !opd_valid_reg[gi] && fpr_cdb.valid
                       && (fpr_cdb.tag == opd_tag_reg[gi]);
         assign upd_opd_valid[gi] = opd_valid_reg[gi] || wake;
         assign upd_data[gi]      = wake ? sign_mod(op_reg[gi], fpr_cdb.data) : opd_data_reg[gi];
         assign cand_valid[gi]    = valid_reg[gi] && upd_opd_valid[gi];
         assign cand_tag[gi]      = tag_reg[gi];
         assign cand_data[gi]     = upd_data[gi];
      end
   endgenerate

   // Ready only looks at stored entries so the issue path never loops back on itself;
   // a full station whose entries are all pending cannot make room this cycle.
   assign stored_req      = |cand_valid[N_ENTRY-1:0];
   assign full            = valid_reg[N_ENTRY-1];
   assign issue_req_ready = !full || (stored_req && fpr_cdb_req_ready);
   assign accept          = issue_req_valid && issue_req_ready;

   // Register-file value beats a same-cycle CDB match
   assign new_opd_valid = fpr_read[0].valid
                          || (fpr_cdb.valid && (fpr_cdb.tag == fpr_read[0].tag));
   assign new_data      = sign_mod(inst_op, fpr_read[0].valid ? fpr_read[0].data : fpr_cdb.data);

   assign cand_valid[N_ENTRY] = accept && new_opd_valid;
   assign cand_tag[N_ENTRY]   = fpr_issue_tag;
   assign cand_data[N_ENTRY]  = new_data;

   assign fpr_cdb_req_valid = |cand_valid;

   always_comb begin
      sel_idx = '0;
      for (int i = N_ENTRY; i >= 0; i--) begin
         if (cand_valid[i]) sel_idx = CNT_W'(i);
      end
   end

   assign tag       = cand_tag[sel_idx];
   assign sel_data  = cand_data[sel_idx];
   assign dispatch  = fpr_cdb_req_valid && fpr_cdb_req_ready;
   assign rm_stored = dispatch && (sel_idx != CNT_W'(N_ENTRY));
   assign store_new = accept && !(dispatch && (sel_idx == CNT_W'(N_ENTRY)));
   assign ins_pos   = count_reg - CNT_W'(rm_stored);

   always_comb begin
      valid_next     = valid_reg;
      opd_valid_next = upd_opd_valid;
      tag_next       = tag_reg;
      op_next        = op_reg;
      opd_tag_next   = opd_tag_reg;
      opd_data_next  = upd_data;

      // Close the gap left by the dispatched entry
      for (int i = 0; i < N_ENTRY - 1; i++) begin
         if (rm_stored && (CNT_W'(i) >= sel_idx)) begin
            valid_next[i]     = valid_reg[i+1];
            opd_valid_next[i] = upd_opd_valid[i+1];
            tag_next[i]       = tag_reg[i+1];
            op_next[i]        = op_reg[i+1];
            opd_tag_next[i]   = opd_tag_reg[i+1];
            opd_data_next[i]  = upd_data[i+1];
         end
      end
      if (rm_stored) valid_next[N_ENTRY-1] = 1'b0;

      for (int i = 0; i < N_ENTRY; i++) begin
         if (store_new && (CNT_W'(i) == ins_pos)) begin
            valid_next[i]     = 1'b1;
            opd_valid_next[i] = new_opd_valid;
            tag_next[i]       = fpr_issue_tag;
            op_next[i]        = inst_op;
            opd_tag_next[i]   = fpr_read[0].tag;
            opd_data_next[i]  = new_data;
         end
      end
   end

   assign count_next = count_reg + CNT_W'(accept) - CNT_W'(dispatch);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg     <= '0;
         opd_valid_reg <= '0;
         count_reg     <= '0;
         result_reg    <= '0;
      end else begin
         valid_reg     <= valid_next;
         opd_valid_reg <= opd_valid_next;
         count_reg     <= count_next;
         result_reg    <= sel_data;
      end
      tag_reg      <= tag_next;
      op_reg       <= op_next;
      opd_tag_reg  <= opd_tag_next;
      opd_data_reg <= opd_data_next;
   end

   assign result = result_reg;
   assign count  = count_reg;

endmodule

// File: tb/tb_fmov_rs.sv
// Randomised and directed bench for fmov_rs: queue-based reference model feeds
// a scoreboard that a separate monitor drains on every granted dispatch.

module tb_fmov_rs;
   import fmov_rs_pkg::*;

   localparam int N = 4;

   logic                 clk, reset;
   logic [1:0]           inst_op;
   cdb_t [1:0]           fpr_read;
   cdb_t                 fpr_cdb;
   logic [ROB_WIDTH-1:0] fpr_issue_tag, tag;
   logic                 issue_req_valid, issue_req_ready;
   logic                 fpr_cdb_req_valid, fpr_cdb_req_ready;
   logic [31:0]          result;
   logic [2:0]           count;

   fmov_rs #(.N_ENTRY(N)) dut (
      .clk(clk), .reset(reset), .inst_op(inst_op), .fpr_read(fpr_read),
      .fpr_cdb(fpr_cdb), .fpr_issue_tag(fpr_issue_tag),
      .issue_req_valid(issue_req_valid), .issue_req_ready(issue_req_ready),
      .fpr_cdb_req_valid(fpr_cdb_req_valid), .fpr_cdb_req_ready(fpr_cdb_req_ready),
      .tag(tag), .result(result), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      logic [1:0]  op;
      bit          rdy;
      logic [3:0]  src;
      logic [31:0] val;
   } ment_t;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] val;
   } exp_t;

   ment_t mq[$];
   exp_t  sb[$];
   int    n_chk  = 0;
   int    n_fail = 0;

   function automatic logic [31:0] sgn(input logic [1:0] op, input logic [31:0] d);
      case (op)
         2'd0:    return d;
         2'd1:    return d ^ 32'h8000_0000;
         2'd2:    return d & 32'h7FFF_FFFF;
         default: return d | 32'h8000_0000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: applied once per cycle after inputs settle
   task automatic model_step();
      int    fr;
      bit    full, exp_rdy, acc, exp_req;
      ment_t ne;
      if (reset) begin
         mq.delete();
         return;
      end
      chk("count", 32'(count), 32'(mq.size()));
      foreach (mq[i]) begin
         if (!mq[i].rdy && fpr_cdb.valid && fpr_cdb.tag == mq[i].src) begin
            mq[i].rdy = 1;
            mq[i].val = sgn(mq[i].op, fpr_cdb.data);
         end
      end
      fr = -1;
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].rdy) fr = i;
      full    = (mq.size() == N);
      exp_rdy = !full || (fr >= 0 && fpr_cdb_req_ready);
      acc     = issue_req_valid && exp_rdy;
      ne.tag  = fpr_issue_tag;
      ne.op   = inst_op;
      ne.src  = fpr_read[0].tag;
      if (fpr_read[0].valid) begin
         ne.rdy = 1; ne.val = sgn(inst_op, fpr_read[0].data);
      end else if (fpr_cdb.valid && fpr_cdb.tag == fpr_read[0].tag) begin
         ne.rdy = 1; ne.val = sgn(inst_op, fpr_cdb.data);
      end else begin
         ne.rdy = 0; ne.val = 32'h0;
      end
      exp_req = (fr >= 0) || (acc && ne.rdy);
      chk("issue_ready", 32'(issue_req_ready), 32'(exp_rdy));
      chk("cdb_req_valid", 32'(fpr_cdb_req_valid), 32'(exp_req));
      if (exp_req) chk("tag", 32'(tag), 32'(fr >= 0 ? mq[fr].tag : ne.tag));
      if (exp_req && fpr_cdb_req_ready) begin
         if (fr >= 0) begin
            sb.push_back('{tag: mq[fr].tag, val: mq[fr].val});
            mq.delete(fr);
            if (acc) mq.push_back(ne);
         end else begin
            sb.push_back('{tag: ne.tag, val: ne.val});
         end
      end else if (acc) begin
         mq.push_back(ne);
      end
   endtask

   task automatic cyc(input bit rst, input bit iv, input logic [1:0] op,
                      input bit rv, input logic [3:0] rt, input logic [31:0] rd,
                      input bit cv, input logic [3:0] ct, input logic [31:0] cd,
                      input logic [3:0] it, input bit rdy);
      @(negedge clk);
      reset             = rst;
      issue_req_valid   = iv;
      inst_op           = op;
      fpr_read[0]       = '{valid: rv, tag: rt, data: rd};
      fpr_read[1]       = '{valid: 1'b1, tag: ~rt, data: ~rd};
      fpr_cdb           = '{valid: cv, tag: ct, data: cd};
      fpr_issue_tag     = it;
      fpr_cdb_req_ready = rdy;
      #1;
      model_step();
   endtask

   task automatic idle(input bit rdy);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd0, rdy);
   endtask

   // Monitor: one scoreboard pop per granted dispatch
   initial begin
      exp_t       e;
      logic [3:0] mt;
      forever begin
         @(negedge clk);
         #4;
         if (!reset && fpr_cdb_req_valid && fpr_cdb_req_ready) begin
            mt = tag;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_dispatch: tag %0d result %h, no dispatch expected", mt, result);
            end else begin
               e = sb.pop_front();
               chk("disp_tag", 32'(mt), 32'(e.tag));
               chk("disp_result", result, e.val);
               $display("dispatch tag=%0d result=%h", mt, result);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; issue_req_valid = 1'b0; inst_op = '0; fpr_read = '0;
      fpr_cdb = '0; fpr_issue_tag = '0; fpr_cdb_req_ready = 1'b0;

      cyc(1, 0, 2'd0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd0, 0);
      cyc(1, 0, 2'd0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0, 4'd0, 0);
      idle(0);
      chk("reset_result", result, 32'h0);

      // Bypass: fneg ready at issue
      cyc(0, 1, 2'd1, 1, 4'd2, 32'h3F80_0000, 0, 4'd0, 32'h0, 4'd7, 1);
      idle(1);
      chk("bypass_result", result, 32'hBF80_0000);

      // Wake-up: fabs pending on tag 5
      cyc(0, 1, 2'd2, 0, 4'd5, 32'h0, 0, 4'd0, 32'h0, 4'd3, 1);
      idle(1);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd5, 32'hC040_0000, 4'd0, 1);
      idle(1);
      chk("wake_result", result, 32'h4040_0000);

      // Oldest first: entries 1 and 3 share source tag 9
      cyc(0, 1, 2'd0, 0, 4'd8,  32'h0, 0, 4'd0, 32'h0, 4'd1, 1);
      cyc(0, 1, 2'd0, 0, 4'd9,  32'h0, 0, 4'd0, 32'h0, 4'd2, 1);
      cyc(0, 1, 2'd0, 0, 4'd10, 32'h0, 0, 4'd0, 32'h0, 4'd3, 1);
      cyc(0, 1, 2'd0, 0, 4'd9,  32'h0, 0, 4'd0, 32'h0, 4'd4, 1);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd9, 32'h1234_5678, 4'd0, 1);
      chk("oldest_tag", 32'(tag), 32'd2);
      idle(1);
      chk("oldest_count3", 32'(count), 32'd3);
      idle(1);
      chk("oldest_count2", 32'(count), 32'd2);

      // Full station: no grant blocks issue, grant lets it through
      cyc(0, 1, 2'd0, 0, 4'd12, 32'h0, 0, 4'd0, 32'h0, 4'd5, 1);
      cyc(0, 1, 2'd0, 0, 4'd13, 32'h0, 0, 4'd0, 32'h0, 4'd6, 1);
      cyc(0, 1, 2'd0, 0, 4'd14, 32'h0, 1, 4'd8, 32'hAAAA_5555, 4'd7, 0);
      chk("full_ready_low", 32'(issue_req_ready), 32'd0);
      cyc(0, 1, 2'd0, 0, 4'd14, 32'h0, 0, 4'd0, 32'h0, 4'd7, 1);
      chk("full_ready_high", 32'(issue_req_ready), 32'd1);
      idle(0);
      chk("full_count", 32'(count), 32'd4);

      // Drain
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd10, 32'h0000_1111, 4'd0, 1);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd12, 32'h8000_2222, 4'd0, 1);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd13, 32'h7000_3333, 4'd0, 1);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd14, 32'hF000_4444, 4'd0, 1);
      idle(1);

      // Same-cycle capture: fnabs from the CDB
      cyc(0, 1, 2'd3, 0, 4'd6, 32'h0, 1, 4'd6, 32'h0000_0001, 4'd9, 1);
      idle(1);
      chk("capture_result", result, 32'h8000_0001);

      // Reset mid-run drops held entries and one issued during reset
      cyc(0, 1, 2'd0, 0, 4'd1, 32'h0, 0, 4'd0, 32'h0, 4'd10, 1);
      cyc(0, 1, 2'd1, 0, 4'd2, 32'h0, 0, 4'd0, 32'h0, 4'd11, 1);
      cyc(0, 1, 2'd2, 0, 4'd3, 32'h0, 0, 4'd0, 32'h0, 4'd12, 1);
      cyc(1, 1, 2'd0, 0, 4'd4, 32'h0, 0, 4'd0, 32'h0, 4'd13, 0);
      idle(1);
      chk("reset_count", 32'(count), 32'd0);
      cyc(0, 0, 2'd0, 0, 4'd0, 32'h0, 1, 4'd1, 32'h5555_5555, 4'd0, 1);
      chk("reset_no_req", 32'(fpr_cdb_req_valid), 32'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
             2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 1) == 1),
             4'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) != 0));
      end
      idle(0);
      idle(0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
